transpose_pingpong: RTL and testbench
=====================================

Name: transpose_pingpong

Overview:
Runtime-sized matrix transpose for the systolic datapath, next generation of the single-buffer transpose unit. It accepts up to COL_DIM input vectors of ROW_DIM lanes and emits up to ROW_DIM transposed vectors of COL_DIM lanes. Two storage banks work in ping-pong, so one tile is filled while the previous tile drains. Both data sides use valid/ready handshakes and sit between the output buffer and the next array feed.

Parameters:
ROW_DIM, 16, lanes per input vector; maximum A
COL_DIM, 16, lanes per output vector; maximum B
DATA_WIDTH, 8, bits per element

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
T_start  in  1  strobe; latches A/B for the next tile when start_ready=1
start_ready  out  1  write side idle and the target bank is free
A  in  $clog2(ROW_DIM)+1  valid lanes per input vector = number of output vectors
B  in  $clog2(COL_DIM)+1  number of input vectors = valid lanes per output vector
data_in  in  ROW_DIM*DATA_WIDTH  input vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  1  data_in is valid
in_ready  out  1  block accepts data_in
data_out  out  COL_DIM*DATA_WIDTH  transposed vector, same lane packing
out_valid  out  1  data_out is valid
out_ready  in  1  consumer accepts data_out
out_last  out  1  marks the final output vector of a tile
T_end  out  1  one-cycle pulse; tile fully drained

Behaviour:
- Reset: all outputs are 0 while reset is high, except start_ready. Write FSM = W_IDLE, read FSM = R_IDLE, full[1:0]=0, wb=rb=0, counters=0. Bank contents are not cleared.
- start_ready = (W_IDLE && !full[wb]); it is 1 in the first cycle after reset deasserts.
- Dimension rule: a value of 0, or a value above the maximum, saturates to the maximum (ROW_DIM for A, COL_DIM for B). The saturated values are latched per bank as cfgA/cfgB.
- Write FSM:
  - W_IDLE --(T_start && start_ready)--> W_FILL, with wr_cnt=0. T_start while not ready is ignored.
  - W_FILL: in_ready=1. Each in_valid&&in_ready writes data_in into row wr_cnt of bank[wb], then wr_cnt++.
  - On the accept where wr_cnt==cfgB-1: full[wb]<=1, wb<=~wb, return to W_IDLE.
- Read FSM:
  - R_IDLE --(full[rb])--> R_DRAIN, with rd_cnt=0.
  - R_DRAIN: out_valid=1. data_out lane j = bank[rb] row j lane rd_cnt for j<cfgB[rb]; lanes j>=cfgB are 0.
  - out_last=1 when rd_cnt==cfgA-1.
  - Each out_valid&&out_ready: rd_cnt++. On the last one: full[rb]<=0, rb<=~rb, R_IDLE, and T_end=1 in the following cycle only.
- data_out is forced to 0 whenever out_valid=0. data_out is held stable while out_valid && !out_ready.
- Latency: last input handshake in cycle n gives the first out_valid in cycle n+2. Throughput is then one vector per cycle with out_ready=1.
- Bank freed and T_start in the same cycle: start_ready uses registered full, so the start is accepted one cycle later.
- Both banks full: start_ready=0, in_ready=0 until a drain completes.
- full[x] is never set and cleared in the same cycle, because writes only target a non-full bank.
- Reset mid-operation: immediate return to the reset state. The partial tile is discarded and T_end is not pulsed.

Decomposition:
- transpose_pkg holds:
  - W_IDLE/W_FILL and R_IDLE/R_DRAIN encodings
  - dim-width localparams
  - the saturate-dim function
- Sub-module transpose_bank is instantiated twice. It provides COL_DIM x ROW_DIM element storage, a row-write port, and a column-read mux with lane masking by cfgB.

Test Plan:
1. Single tile, A=10, B=10. Row 0 = lanes 0..15 = 0x10,0x0F,...,0x01; rows 1..9 = 0. Expect 10 outputs; output i has lane0 = row0 lane i (0x10,0x0F,...,0x07) and all other lanes 0. First out_valid 2 cycles after the last accept; out_last on output 9; T_end one cycle later.
2. Back-to-back tiles, A=B=16, element(r,c)=r*16+c for tile 0 and +1 for tile 1. Tile 1 fills during the tile 0 drain. Expect output i lane j = j*16+i (+1 for tile 1). Tile 1 outputs start the cycle after the tile 0 drain completes.
3. Backpressure: hold out_ready=0 for 5 cycles mid-drain. Expect out_valid=1 and data_out stable. Fill a second tile, then T_start is refused (start_ready=0, in_ready=0) until the drain resumes and completes.
4. Dimension edges: A=0,B=0 gives 16 outputs of 16 lanes. A=1,B=1 with data_in=0xAB in lane0 gives a single output 0x..00AB with out_last=1. A=20 saturates to 16.
5. Reset asserted mid-fill (row 4) and separately mid-drain (output 3): all outputs 0, start_ready=1 after release, and a fresh A=4,B=4 tile then transposes correctly.
6. Handshake bubbles: in_valid toggled every other cycle with A=3,B=5. Expect exactly 5 rows written and 3 outputs each with 5 valid lanes; lanes 5..15 are 0.

Source files
------------

// File: rtl/transpose_pkg.sv
// Shared FSM encodings, default dimensions and the dimension-saturation helper
// for the ping-pong transpose unit.
package transpose_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rstate_t;

  localparam int DEF_ROW_DIM    = 16;
  localparam int DEF_COL_DIM    = 16;
  localparam int DEF_DATA_WIDTH = 8;

  // Width of a dimension field able to hold 0..max_dim inclusive
  function automatic int dim_w(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  // Zero or out-of-range dimensions fall back to the full size
  function automatic int unsigned sat_dim(input int unsigned v, input int unsigned max_dim);
    if ((v == 32'd0) || (v > max_dim)) begin
      return max_dim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One tile of COL_DIM rows x ROW_DIM lanes: whole-row writes, column reads
// with output lanes at or beyond the tile's row count forced to zero.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int ROW_DIM    = DEF_ROW_DIM,
  parameter int COL_DIM    = DEF_COL_DIM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(COL_DIM)-1:0]    i_wr_row,
  input  logic [ROW_DIM*DATA_WIDTH-1:0] i_wr_data,
  input  logic [$clog2(ROW_DIM)-1:0]    i_rd_col,
  input  logic [$clog2(COL_DIM):0]      i_cfg_b,
  output logic [COL_DIM*DATA_WIDTH-1:0] o_rd_data
);

  localparam int BW = dim_w(COL_DIM);

  logic [DATA_WIDTH-1:0] r_mem [COL_DIM][ROW_DIM];

  // Row write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < ROW_DIM; l++) begin
        r_mem[i_wr_row][l] <= i_wr_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Column read with lane masking
  always_comb begin
    o_rd_data = {(COL_DIM*DATA_WIDTH){1'b0}};
    for (int j = 0; j < COL_DIM; j++) begin
      if (BW'(j) < i_cfg_b) begin
        o_rd_data[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[j][i_rd_col];
      end else begin
        o_rd_data[j*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: rtl/transpose_pingpong.sv
// Runtime-sized matrix transpose with two banks in ping-pong: one tile fills
// while the previous one drains, valid/ready on both data sides.
module transpose_pingpong
  import transpose_pkg::*;
#(
  parameter int ROW_DIM    = DEF_ROW_DIM,
  parameter int COL_DIM    = DEF_COL_DIM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          T_start,
  output logic                          start_ready,
  input  logic [$clog2(ROW_DIM):0]      A,
  input  logic [$clog2(COL_DIM):0]      B,
  input  logic [ROW_DIM*DATA_WIDTH-1:0] data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [COL_DIM*DATA_WIDTH-1:0] data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          T_end
);

  localparam int AW = dim_w(ROW_DIM);
  localparam int BW = dim_w(COL_DIM);
  localparam int CW = $clog2(ROW_DIM);
  localparam int RW = $clog2(COL_DIM);
  localparam int VW = COL_DIM * DATA_WIDTH;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [1:0]    r_full;
  logic          r_wb;
  logic          r_rb;
  logic [BW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [AW-1:0] r_cfg_a [2];
  logic [BW-1:0] r_cfg_b [2];
  logic [VW-1:0] r_data_out;
  logic          r_t_end;

  logic [AW-1:0] w_a_sat;
  logic [BW-1:0] w_b_sat;
  logic          w_start_fire;
  logic          w_wr_fire;
  logic          w_wr_last;
  logic          w_drain_start;
  logic          w_rd_fire;
  logic          w_rd_last;
  logic [CW-1:0] w_rd_col;
  logic [VW-1:0] w_bank_rd [2];
  logic [VW-1:0] w_rd_data;

  assign w_a_sat = AW'(sat_dim(32'(A), 32'(ROW_DIM)));
  assign w_b_sat = BW'(sat_dim(32'(B), 32'(COL_DIM)));

  // start_ready looks at registered full, so a bank freed this cycle is usable next cycle
  assign start_ready = (r_wstate == W_IDLE) && !r_full[r_wb];
  assign out_valid   = (r_rstate == R_DRAIN);
  assign out_last    = (r_rstate == R_DRAIN) && (r_rd_cnt == (r_cfg_a[r_rb] - AW'(1'b1)));
  assign data_out    = r_data_out;
  assign T_end       = r_t_end;
  assign w_rd_data   = w_bank_rd[r_rb];

  // Write FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  // Write FSM next state and handshake decode
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_start_fire = 1'b0;
    w_wr_fire    = 1'b0;
    w_wr_last    = 1'b0;
    in_ready     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (T_start && start_ready) begin
          w_start_fire = 1'b1;
          w_wstate_nxt = W_FILL;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr_fire = 1'b1;
          if (r_wr_cnt == (r_cfg_b[r_wb] - BW'(1'b1))) begin
            w_wr_last    = 1'b1;
            w_wstate_nxt = W_IDLE;
          end else begin
            w_wstate_nxt = W_FILL;
          end
        end else begin
          w_wstate_nxt = W_FILL;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // Write side datapath: tile config latch, row counter, bank toggle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt   <= {BW{1'b0}};
      r_wb       <= 1'b0;
      r_cfg_a[0] <= {AW{1'b0}};
      r_cfg_a[1] <= {AW{1'b0}};
      r_cfg_b[0] <= {BW{1'b0}};
      r_cfg_b[1] <= {BW{1'b0}};
    end else begin
      if (w_start_fire) begin
        r_wr_cnt      <= {BW{1'b0}};
        r_cfg_a[r_wb] <= w_a_sat;
        r_cfg_b[r_wb] <= w_b_sat;
      end else if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_cnt <= {BW{1'b0}};
          r_wb     <= ~r_wb;
        end else begin
          r_wr_cnt <= r_wr_cnt + BW'(1'b1);
        end
      end
    end
  end

  // Bank occupancy; writer and reader always target different banks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_wr_last && (r_wb == 1'(i))) begin
          r_full[i] <= 1'b1;
        end else if (w_rd_last && (r_rb == 1'(i))) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // Read FSM next state and handshake decode
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_drain_start = 1'b0;
    w_rd_fire     = 1'b0;
    w_rd_last     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (r_full[r_rb]) begin
          w_drain_start = 1'b1;
          w_rstate_nxt  = R_DRAIN;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_DRAIN: begin
        if (out_ready) begin
          w_rd_fire = 1'b1;
          if (r_rd_cnt == (r_cfg_a[r_rb] - AW'(1'b1))) begin
            w_rd_last    = 1'b1;
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rstate_nxt = R_DRAIN;
          end
        end else begin
          w_rstate_nxt = R_DRAIN;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // data_out is registered, so the bank is read one column ahead of the output
  always_comb begin
    if (r_rstate == R_DRAIN) begin
      w_rd_col = CW'(r_rd_cnt + AW'(1'b1));
    end else begin
      w_rd_col = {CW{1'b0}};
    end
  end

  // Read side datapath: column counter, bank toggle, output vector, T_end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt   <= {AW{1'b0}};
      r_rb       <= 1'b0;
      r_data_out <= {VW{1'b0}};
      r_t_end    <= 1'b0;
    end else begin
      r_t_end <= w_rd_last;
      if (w_drain_start) begin
        r_rd_cnt   <= {AW{1'b0}};
        r_data_out <= w_rd_data;
      end else if (w_rd_fire) begin
        if (w_rd_last) begin
          r_rd_cnt   <= {AW{1'b0}};
          r_rb       <= ~r_rb;
          r_data_out <= {VW{1'b0}};
        end else begin
          r_rd_cnt   <= r_rd_cnt + AW'(1'b1);
          r_data_out <= w_rd_data;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    transpose_bank #(
      .ROW_DIM   (ROW_DIM),
      .COL_DIM   (COL_DIM),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk      (clk),
      .i_we     (w_wr_fire && (r_wb == 1'(g))),
      .i_wr_row (r_wr_cnt[RW-1:0]),
      .i_wr_data(data_in),
      .i_rd_col (w_rd_col),
      .i_cfg_b  (r_cfg_b[g]),
      .o_rd_data(w_bank_rd[g])
    );
  end

endmodule

// File: tb/tb_transpose_pingpong.sv
// Scoreboard bench for transpose_pingpong: expected columns are queued when a
// tile is written and compared as the DUT emits them.
module tb_transpose_pingpong;

  localparam int RD = 16;
  localparam int CD = 16;
  localparam int DW = 8;
  localparam int VW = CD * DW;

  typedef logic [VW:0] cv_t;
  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           T_start = 1'b0;
  logic           start_ready;
  logic [4:0]     A = 5'd0;
  logic [4:0]     B = 5'd0;
  logic [RD*DW-1:0] data_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [VW-1:0]  data_out;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;
  logic           T_end;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [7:0] tile [16][16];
  int   cyc = 0;
  int   out_cnt = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   tend_cyc = 0;
  int   last_acc = 0;
  logic pend_tend = 1'b0;
  logic stall_v = 1'b0;
  logic prev_valid = 1'b0;
  logic [VW:0] stall_d = '0;

  transpose_pingpong #(.ROW_DIM(RD), .COL_DIM(CD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .T_start(T_start), .start_ready(start_ready),
    .A(A), .B(B), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .T_end(T_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input cv_t got, input cv_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return ((v == 0) || (v > 16)) ? 16 : v;
  endfunction

  function automatic logic [RD*DW-1:0] pack_row(input int r);
    logic [RD*DW-1:0] v;
    for (int l = 0; l < RD; l++) v[l*DW +: DW] = tile[r][l];
    return v;
  endfunction

  // Output monitor: scoreboard pop, T_end timing, stall hold, idle zero
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend_tend  <= 1'b0;
      stall_v    <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      check_eq("t_end", cv_t'(T_end), cv_t'(pend_tend));
      if (!out_valid) check_eq("dout_idle", cv_t'(data_out), cv_t'(0));
      if (stall_v) begin
        check_eq("hold_valid", cv_t'(out_valid), cv_t'(1));
        check_eq("hold_data", cv_t'({out_last, data_out}), stall_d);
      end
      stall_v <= out_valid && !out_ready;
      stall_d <= {out_last, data_out};
      if (out_valid && !prev_valid) begin
        rise_cnt <= rise_cnt + 1;
        rise_cyc <= cyc;
      end
      prev_valid <= out_valid;
      if (T_end) tend_cyc <= cyc;
      pend_tend <= 1'b0;
      if (out_valid && out_ready) begin
        check_eq("q_nonempty", cv_t'(exp_q.size() != 0), cv_t'(1));
        if (exp_q.size() != 0) begin
          check_eq("data_out", cv_t'(data_out), cv_t'(exp_q[0].data));
          check_eq("out_last", cv_t'(out_last), cv_t'(exp_q[0].last));
          pend_tend <= exp_q[0].last;
          void'(exp_q.pop_front());
        end
        out_cnt <= out_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int a, input int b);
    int n;
    n = 0;
    A = 5'(a);
    B = 5'(b);
    T_start = 1'b1;
    while (!start_ready && n < 300) begin tick(); n++; end
    check_eq("start_ready", cv_t'(start_ready), cv_t'(1));
    tick();
    T_start = 1'b0;
  endtask

  task automatic send_rows(input int nrows, input bit bubble);
    int n;
    for (int r = 0; r < nrows; r++) begin
      data_in  = pack_row(r);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin tick(); n++; end
      check_eq("in_ready", cv_t'(in_ready), cv_t'(1));
      tick();
      last_acc = cyc - 1;
      if (bubble) begin
        in_valid = 1'b0;
        data_in  = {4{$urandom}};
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input int a, input int b);
    int   sa;
    int   sb;
    exp_t e;
    sa = sat16(a);
    sb = sat16(b);
    for (int i = 0; i < sa; i++) begin
      e.data = '0;
      for (int j = 0; j < sb; j++) e.data[j*DW +: DW] = tile[j][i];
      e.last = (i == sa - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_tile(input int a, input int b, input bit bubble);
    start_tile(a, b);
    send_rows(sat16(b), bubble);
    push_exp(a, b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    check_eq("drained", cv_t'(exp_q.size()), cv_t'(0));
    repeat (3) tick();
  endtask

  task automatic wait_rise(input int r0);
    int n;
    n = 0;
    while (rise_cnt <= r0 && n < 300) begin tick(); n++; end
    check_eq("rise_seen", cv_t'(rise_cnt > r0), cv_t'(1));
  endtask

  task automatic rand_tile();
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) tile[r][l] = 8'($urandom);
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, "_outs"}, cv_t'({out_valid, in_ready, out_last, T_end, data_out}), cv_t'(0));
    check_eq({tag, "_start_ready"}, cv_t'(start_ready), cv_t'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int base;
    int n;

    // Reset state
    repeat (3) tick();
    check_rst("reset");
    reset = 1'b0;
    check_eq("start_ready_post_reset", cv_t'(start_ready), cv_t'(1));
    tick();

    // 1: single 10x10 tile, latency 2
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) tile[r][l] = (r == 0) ? 8'(16 - l) : 8'h00;
    r0 = rise_cnt;
    run_tile(10, 10, 1'b0);
    wait_rise(r0);
    check_eq("latency", cv_t'(rise_cyc - last_acc), cv_t'(2));
    wait_drain();

    // 2: back-to-back 16x16 tiles
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) tile[r][l] = 8'(r * 16 + l);
    r0 = rise_cnt;
    run_tile(16, 16, 1'b0);
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 16; l++) tile[r][l] = 8'(r * 16 + l + 1);
    run_tile(16, 16, 1'b0);
    wait_rise(r0 + 1);
    check_eq("b2b_gap", cv_t'(rise_cyc - tend_cyc), cv_t'(1));
    wait_drain();

    // 3: backpressure with both banks full
    out_ready = 1'b0;
    rand_tile();
    run_tile(16, 16, 1'b0);
    rand_tile();
    run_tile(16, 16, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    T_start = 1'b1;
    A = 5'd4;
    B = 5'd4;
    repeat (5) begin
      check_eq("bp_start_ready", cv_t'(start_ready), cv_t'(0));
      check_eq("bp_in_ready", cv_t'(in_ready), cv_t'(0));
      check_eq("bp_out_valid", cv_t'(out_valid), cv_t'(1));
      tick();
    end
    T_start = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check_eq("bp_start_after", cv_t'(start_ready), cv_t'(1));

    // 4: dimension edges
    rand_tile();
    run_tile(0, 0, 1'b0);
    wait_drain();
    rand_tile();
    tile[0][0] = 8'hAB;
    run_tile(1, 1, 1'b0);
    wait_drain();
    rand_tile();
    run_tile(20, 7, 1'b0);
    wait_drain();

    // 5a: reset during fill of row 4
    rand_tile();
    start_tile(8, 8);
    send_rows(4, 1'b0);
    data_in  = pack_row(4);
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    check_rst("rst_fill");
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    check_eq("rst_fill_start_ready", cv_t'(start_ready), cv_t'(1));
    rand_tile();
    run_tile(4, 4, 1'b0);
    wait_drain();

    // 5b: reset while output 3 is presented
    rand_tile();
    base = out_cnt;
    run_tile(8, 8, 1'b0);
    n = 0;
    while (out_cnt < base + 3 && n < 300) begin tick(); n++; end
    check_eq("rst_drain_reached", cv_t'(out_cnt >= base + 3), cv_t'(1));
    reset = 1'b1;
    #1;
    check_rst("rst_drain");
    tick();
    reset = 1'b0;
    check_eq("rst_drain_start_ready", cv_t'(start_ready), cv_t'(1));
    rand_tile();
    run_tile(4, 4, 1'b0);
    wait_drain();

    // 6: input bubbles, A=3 B=5
    rand_tile();
    run_tile(3, 5, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
